// File: rtl/mips_pkg.sv
//------------------------------------------------------------------------------
// Module   : mips_pkg
// Brief    : Shared forward-select encodings, hazard FSM states and helpers.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_STALLED = 1'b1
    } hz_state_e;

    // The younger producer (EX/MEM) wins; r0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       rw_mem,
        input logic [4:0] dst_mem,
        input logic       rw_wb,
        input logic [4:0] dst_wb
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (rw_mem && (dst_mem != 5'd0) && (dst_mem == src)) begin
            sel = FWD_MEM;
        end else if (rw_wb && (dst_wb != 5'd0) && (dst_wb == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_sat_counter.sv
//------------------------------------------------------------------------------
// Module   : mips_sat_counter
// Brief    : Saturating up-counter with synchronous active-high reset.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mips_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/mips_hazard_fwd.sv
//------------------------------------------------------------------------------
// Module   : mips_hazard_fwd
// Brief    : 5-stage MIPS forwarding selects, load-use stall and branch flush.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mips_hazard_fwd
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       RsID,
    input  logic [4:0]       RtID,
    input  logic             MemReadEX,
    input  logic             RegWriteEX,
    input  logic             RegDstEX,
    input  logic [4:0]       RsEX,
    input  logic [4:0]       RtEX,
    input  logic [4:0]       RdEX,
    input  logic             BranchTaken,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             CtrlZeroID,
    output logic             FlushIFID,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FwdCnt
);

    logic [4:0] dest_ex;
    logic       regwrite_mem_q, regwrite_mem_d;
    logic [4:0] dest_mem_q,     dest_mem_d;
    logic       regwrite_wb_q,  regwrite_wb_d;
    logic [4:0] dest_wb_q,      dest_wb_d;
    hz_state_e  state_q,        state_d;
    logic       load_use;
    logic       stall_inc;
    logic       fwd_inc;

    // Shadow copies of the destination pipeline; the real EX/MEM and MEM/WB
    // registers live in the datapath, this block only tracks what it needs.
    always_comb begin
        dest_ex        = RegDstEX ? RdEX : RtEX;
        regwrite_mem_d = RegWriteEX;
        dest_mem_d     = dest_ex;
        regwrite_wb_d  = regwrite_mem_q;
        dest_wb_d      = dest_mem_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            regwrite_mem_q <= 1'b0;
            dest_mem_q     <= 5'd0;
            regwrite_wb_q  <= 1'b0;
            dest_wb_q      <= 5'd0;
            state_q        <= ST_RUN;
        end else begin
            regwrite_mem_q <= regwrite_mem_d;
            dest_mem_q     <= dest_mem_d;
            regwrite_wb_q  <= regwrite_wb_d;
            dest_wb_q      <= dest_wb_d;
            state_q        <= state_d;
        end
    end

    assign load_use = MemReadEX && (RtEX != 5'd0) && ((RtEX == RsID) || (RtEX == RtID));

    always_comb begin
        state_d    = ST_RUN;
        ForwardA   = FWD_RF;
        ForwardB   = FWD_RF;
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        CtrlZeroID = 1'b0;
        FlushIFID  = 1'b0;
        if (!RST) begin
            ForwardA = fwd_sel(RsEX, regwrite_mem_q, dest_mem_q, regwrite_wb_q, dest_wb_q);
            ForwardB = fwd_sel(RtEX, regwrite_mem_q, dest_mem_q, regwrite_wb_q, dest_wb_q);
            // A second hazard right after a bubble can only come from malformed
            // input, so STALLED never stalls again.
            if (state_q == ST_RUN) begin
                if (BranchTaken) begin
                    FlushIFID  = 1'b1;
                    CtrlZeroID = load_use;
                end else if (load_use) begin
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    CtrlZeroID = 1'b1;
                    state_d    = ST_STALLED;
                end
            end else begin
                FlushIFID = BranchTaken;
            end
        end
    end

    assign stall_inc = ~PCWrite;
    assign fwd_inc   = (ForwardA != FWD_RF) || (ForwardB != FWD_RF);

    mips_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (CLK),
        .rst   (RST),
        .inc   (stall_inc),
        .count (StallCnt)
    );

    mips_sat_counter #(.WIDTH(CNT_W)) u_fwd_cnt (
        .clk   (CLK),
        .rst   (RST),
        .inc   (fwd_inc),
        .count (FwdCnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_mips_hazard_fwd.sv
//------------------------------------------------------------------------------
// Module   : tb_mips_hazard_fwd
// Brief    : Scoreboard bench for mips_hazard_fwd forwarding, stall and flush.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mips_hazard_fwd;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [4:0]  RsID = '0, RtID = '0, RsEX = '0, RtEX = '0, RdEX = '0;
    logic        MemReadEX = 1'b0, RegWriteEX = 1'b0, RegDstEX = 1'b0, BranchTaken = 1'b0;
    logic [1:0]  ForwardA, ForwardB, sForwardA, sForwardB;
    logic        PCWrite, IFIDWrite, CtrlZeroID, FlushIFID;
    logic        sPCWrite, sIFIDWrite, sCtrlZeroID, sFlushIFID;
    logic [15:0] StallCnt, FwdCnt;
    logic [3:0]  sStallCnt, sFwdCnt;

    always #5 CLK = ~CLK;

    mips_hazard_fwd dut (
        .CLK(CLK), .RST(RST), .RsID(RsID), .RtID(RtID),
        .MemReadEX(MemReadEX), .RegWriteEX(RegWriteEX), .RegDstEX(RegDstEX),
        .RsEX(RsEX), .RtEX(RtEX), .RdEX(RdEX), .BranchTaken(BranchTaken),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .PCWrite(PCWrite),
        .IFIDWrite(IFIDWrite), .CtrlZeroID(CtrlZeroID), .FlushIFID(FlushIFID),
        .StallCnt(StallCnt), .FwdCnt(FwdCnt)
    );

    // Narrow-counter copy so saturation is reachable in a short run.
    mips_hazard_fwd #(.CNT_W(4)) dut_sat (
        .CLK(CLK), .RST(RST), .RsID(RsID), .RtID(RtID),
        .MemReadEX(MemReadEX), .RegWriteEX(RegWriteEX), .RegDstEX(RegDstEX),
        .RsEX(RsEX), .RtEX(RtEX), .RdEX(RdEX), .BranchTaken(BranchTaken),
        .ForwardA(sForwardA), .ForwardB(sForwardB), .PCWrite(sPCWrite),
        .IFIDWrite(sIFIDWrite), .CtrlZeroID(sCtrlZeroID), .FlushIFID(sFlushIFID),
        .StallCnt(sStallCnt), .FwdCnt(sFwdCnt)
    );

    typedef struct packed {
        logic       rst, br, mr, rw, rdst;
        logic [4:0] rsid, rtid, rsex, rtex, rdex;
    } stim_t;

    // {ForwardA, ForwardB, PCWrite, IFIDWrite, CtrlZeroID, FlushIFID, StallCnt, FwdCnt}
    typedef logic [39:0] obs_t;

    obs_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_sc = 16'd0;
    logic [15:0] exp_fc = 16'd0;

    function automatic stim_t mk(input logic rst, br, mr, rw, rdst,
                                 input logic [4:0] rsid, rtid, rsex, rtex, rdex);
        stim_t s;
        s = '{rst, br, mr, rw, rdst, rsid, rtid, rsex, rtex, rdex};
        return s;
    endfunction

    // Drives one cycle, pushes the expected outputs, then advances the counter model.
    task automatic apply(input stim_t s, input logic [7:0] ctl);
        @(posedge CLK);
        #1;
        RST = s.rst; BranchTaken = s.br; MemReadEX = s.mr; RegWriteEX = s.rw;
        RegDstEX = s.rdst; RsID = s.rsid; RtID = s.rtid; RsEX = s.rsex;
        RtEX = s.rtex; RdEX = s.rdex;
        sb.push_back({ctl, exp_sc, exp_fc});
        if (s.rst) begin
            exp_sc = 16'd0;
            exp_fc = 16'd0;
        end else begin
            if (!ctl[3] && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
            if (ctl[7:4] != 4'd0 && exp_fc != 16'hFFFF) exp_fc = exp_fc + 16'd1;
        end
        @(negedge CLK);
    endtask

    function automatic obs_t observed();
        return {ForwardA, ForwardB, PCWrite, IFIDWrite, CtrlZeroID, FlushIFID, StallCnt, FwdCnt};
    endfunction

    task automatic test_reset();
        stim_t st; obs_t e, o;
        st = mk(1, 0, 1, 1, 1, 5'd7, 5'd0, 5'd5, 5'd7, 5'd5);
        for (int i = 0; i < 3; i++) begin
            apply(st, 8'b00_00_1100);
            e = sb.pop_front(); o = observed(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL reset cyc%0d got %h want %h", i, o, e); end
        end
    endtask

    task automatic test_ex_hazard();
        stim_t st [4]; logic [7:0] ex [4]; obs_t e, o;
        st = '{mk(0,0,0,1,1, 0,0, 0,0,3), mk(0,0,0,0,0, 0,0, 3,0,0),
               mk(0,0,0,0,0, 0,0, 0,3,0), mk(0,0,0,0,0, 0,0, 0,0,0)};
        ex = '{8'b00_00_1100, 8'b10_00_1100, 8'b00_01_1100, 8'b00_00_1100};
        for (int i = 0; i < 4; i++) begin
            apply(st[i], ex[i]);
            e = sb.pop_front(); o = observed(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL ex_hazard cyc%0d got %h want %h", i, o, e); end
        end
    endtask

    task automatic test_double_hazard();
        stim_t st [4]; logic [7:0] ex [4]; obs_t e, o;
        st = '{mk(0,0,0,1,1, 0,0, 0,0,4), mk(0,0,0,1,1, 0,0, 0,0,4),
               mk(0,0,0,0,0, 0,0, 0,4,0), mk(0,0,0,0,0, 0,0, 0,0,0)};
        ex = '{8'b00_00_1100, 8'b00_00_1100, 8'b00_10_1100, 8'b00_00_1100};
        for (int i = 0; i < 4; i++) begin
            apply(st[i], ex[i]);
            e = sb.pop_front(); o = observed(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL double_hazard cyc%0d got %h want %h", i, o, e); end
        end
    endtask

    task automatic test_load_use();
        stim_t st [4]; logic [7:0] ex [4]; obs_t e, o;
        st = '{mk(0,0,1,1,0, 7,0, 0,7,0), mk(0,0,0,0,0, 7,0, 0,0,0),
               mk(0,0,0,0,0, 0,0, 7,0,0), mk(0,0,0,0,0, 0,0, 0,0,0)};
        ex = '{8'b00_00_0010, 8'b00_00_1100, 8'b01_00_1100, 8'b00_00_1100};
        for (int i = 0; i < 4; i++) begin
            apply(st[i], ex[i]);
            e = sb.pop_front(); o = observed(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL load_use cyc%0d got %h want %h", i, o, e); end
        end
    endtask

    task automatic test_double_bubble();
        stim_t st [4]; logic [7:0] ex [4]; obs_t e, o;
        st = '{mk(0,0,1,0,0, 8,0, 0,8,0), mk(0,0,1,0,0, 8,0, 0,8,0),
               mk(0,0,1,0,0, 8,0, 0,8,0), mk(0,0,0,0,0, 0,0, 0,0,0)};
        ex = '{8'b00_00_0010, 8'b00_00_1100, 8'b00_00_0010, 8'b00_00_1100};
        for (int i = 0; i < 4; i++) begin
            apply(st[i], ex[i]);
            e = sb.pop_front(); o = observed(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL double_bubble cyc%0d got %h want %h", i, o, e); end
        end
    endtask

    task automatic test_reg_zero();
        stim_t st [3]; logic [7:0] ex [3]; obs_t e, o;
        st = '{mk(0,0,0,1,1, 0,0, 0,0,0), mk(0,0,1,0,0, 0,0, 0,0,0),
               mk(0,0,0,0,0, 0,0, 0,0,0)};
        ex = '{8'b00_00_1100, 8'b00_00_1100, 8'b00_00_1100};
        for (int i = 0; i < 3; i++) begin
            apply(st[i], ex[i]);
            e = sb.pop_front(); o = observed(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL reg_zero cyc%0d got %h want %h", i, o, e); end
        end
    endtask

    task automatic test_branch();
        stim_t st [5]; logic [7:0] ex [5]; obs_t e, o;
        st = '{mk(0,1,1,0,0, 9,0, 0,9,0), mk(0,0,1,0,0, 9,0, 0,9,0),
               mk(0,0,0,0,0, 0,0, 0,0,0), mk(0,1,0,0,0, 0,0, 0,0,0),
               mk(0,0,0,0,0, 0,0, 0,0,0)};
        ex = '{8'b00_00_1111, 8'b00_00_0010, 8'b00_00_1100, 8'b00_00_1101, 8'b00_00_1100};
        for (int i = 0; i < 5; i++) begin
            apply(st[i], ex[i]);
            e = sb.pop_front(); o = observed(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL branch cyc%0d got %h want %h", i, o, e); end
        end
    endtask

    task automatic test_reset_mid_stall();
        stim_t st [4]; logic [7:0] ex [4]; obs_t e, o;
        st = '{mk(0,0,1,1,1, 0,6, 0,6,2), mk(1,0,1,1,1, 0,6, 2,6,2),
               mk(0,0,1,0,0, 0,6, 2,6,0), mk(0,0,0,0,0, 0,0, 0,0,0)};
        ex = '{8'b00_00_0010, 8'b00_00_1100, 8'b00_00_0010, 8'b00_00_1100};
        for (int i = 0; i < 4; i++) begin
            apply(st[i], ex[i]);
            e = sb.pop_front(); o = observed(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL reset_mid_stall cyc%0d got %h want %h", i, o, e); end
        end
    endtask

    task automatic test_saturation();
        obs_t e, o;
        for (int i = 0; i < 40; i++) begin
            apply(mk(0,0,1,0,0, 3,0, 0,3,0), (i % 2 == 0) ? 8'b00_00_0010 : 8'b00_00_1100);
            e = sb.pop_front(); o = observed(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL sat_stall cyc%0d got %h want %h", i, o, e); end
        end
        for (int i = 0; i < 20; i++) begin
            apply(mk(0,0,0,1,1, 0,0, 5,0,5), (i == 0) ? 8'b00_00_1100 : 8'b10_00_1100);
            e = sb.pop_front(); o = observed(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL sat_fwd cyc%0d got %h want %h", i, o, e); end
        end
        apply(mk(0,0,0,0,0, 0,0, 0,0,0), 8'b00_00_1100);
        e = sb.pop_front(); o = observed(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL sat_final got %h want %h", o, e); end
        n_cmp++;
        if ({sStallCnt, sFwdCnt} !== 8'hFF) begin
            n_bad++;
            $display("FAIL sat_narrow got %h want ff", {sStallCnt, sFwdCnt});
        end
    endtask

    initial begin
        test_reset();
        test_ex_hazard();
        test_double_hazard();
        test_load_use();
        test_double_bubble();
        test_reg_zero();
        test_branch();
        test_reset_mid_stall();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
